// File: rtl/load_store_unit.sv
// Memory-access stage in front of a byte-addressed, big-endian word memory.
// Adds sub-word loads with extension, and sub-word stores done as read-modify-write.
module load_store_unit #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, FLT, RD, CAP, WR, DONE} stateType;

    stateType    state;
    logic        storeReg;
    logic        unsignedReg;
    logic [1:0]  sizeReg;
    logic [1:0]  offsetReg;
    logic [15:0] storeDataReg;

    logic [32:0] reqBytes;
    logic [32:0] lastByte;
    logic        reqFault;
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic [31:0] loadValue;
    logic [31:0] mergedWord;

    // The last touched byte is computed one bit wider so addresses near 2^32 cannot wrap into range.
    always_comb begin
        reqBytes = 33'd4;
        case (size)
            2'b00:   reqBytes = 33'd1;
            2'b01:   reqBytes = 33'd2;
            default: reqBytes = 33'd4;
        endcase
        lastByte = {1'b0, addr} + reqBytes - 33'd1;
        reqFault = (size == 2'b11)
                || (size == 2'b01 && addr[0])
                || (size == 2'b10 && addr[1:0] != 2'b00)
                || (lastByte >= 33'(MEM_BYTES));
    end

    always_comb begin
        byteLane = mem_rdata[31:24];
        case (offsetReg)
            2'd1:    byteLane = mem_rdata[23:16];
            2'd2:    byteLane = mem_rdata[15:8];
            2'd3:    byteLane = mem_rdata[7:0];
            default: byteLane = mem_rdata[31:24];
        endcase
        halfLane = offsetReg[1] ? mem_rdata[15:0] : mem_rdata[31:16];

        loadValue = mem_rdata;
        if (sizeReg == 2'b00) begin
            loadValue = unsignedReg ? {24'd0, byteLane} : {{24{byteLane[7]}}, byteLane};
        end else if (sizeReg == 2'b01) begin
            loadValue = unsignedReg ? {16'd0, halfLane} : {{16{halfLane[15]}}, halfLane};
        end

        mergedWord = mem_rdata;
        if (sizeReg == 2'b00) begin
            case (offsetReg)
                2'd1:    mergedWord[23:16] = storeDataReg[7:0];
                2'd2:    mergedWord[15:8]  = storeDataReg[7:0];
                2'd3:    mergedWord[7:0]   = storeDataReg[7:0];
                default: mergedWord[31:24] = storeDataReg[7:0];
            endcase
        end else if (sizeReg == 2'b01) begin
            if (offsetReg[1]) mergedWord[15:0] = storeDataReg;
            else              mergedWord[31:16] = storeDataReg;
        end
    end

    // mem_wdata doubles as the write buffer for the merged read-modify-write word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            load_data    <= 32'd0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            storeReg     <= 1'b0;
            unsignedReg  <= 1'b0;
            sizeReg      <= 2'b00;
            offsetReg    <= 2'b00;
            storeDataReg <= 16'd0;
        end else begin
            done      <= 1'b0;
            fault     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        storeReg     <= is_store;
                        unsignedReg  <= is_unsigned;
                        sizeReg      <= size;
                        offsetReg    <= addr[1:0];
                        storeDataReg <= store_data[15:0];
                        busy         <= 1'b1;
                        if (reqFault) begin
                            state <= FLT;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else if (is_store && size == 2'b10) begin
                            state     <= WR;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= store_data;
                            mem_write <= 1'b1;
                        end else begin
                            state    <= RD;
                            mem_addr <= {addr[31:2], 2'b00};
                            mem_read <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    if (storeReg) begin
                        state     <= WR;
                        mem_wdata <= mergedWord;
                        mem_write <= 1'b1;
                    end else begin
                        state     <= DONE;
                        load_data <= loadValue;
                        done      <= 1'b1;
                    end
                end
                WR: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, transaction-level reference model,
// directed cases followed by randomized requests.
module tb_load_store_unit;

    localparam int MEM_BYTES = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        is_unsigned = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        busy, done, fault, mem_read, mem_write;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    logic [7:0]  mem [0:MEM_BYTES-1];
    logic [7:0]  refMem [0:MEM_BYTES-1];
    logic        preWe = 1'b0;
    logic [7:0]  preAddr = 8'd0;
    logic [7:0]  preData = 8'd0;
    logic [31:0] expLoadData = 32'd0;
    int          total = 0;
    int          bad = 0;
    int          overlapCount = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .size(size),
        .is_unsigned(is_unsigned), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .fault(fault), .load_data(load_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    // Synchronous big-endian memory: read data appears the cycle after mem_read.
    always @(posedge clk) begin
        if (preWe) mem[preAddr] <= preData;
        if (mem_write) begin
            mem[{mem_addr[7:2], 2'd0}] <= mem_wdata[31:24];
            mem[{mem_addr[7:2], 2'd1}] <= mem_wdata[23:16];
            mem[{mem_addr[7:2], 2'd2}] <= mem_wdata[15:8];
            mem[{mem_addr[7:2], 2'd3}] <= mem_wdata[7:0];
        end
        if (mem_read) begin
            mem_rdata <= {mem[{mem_addr[7:2], 2'd0}], mem[{mem_addr[7:2], 2'd1}],
                          mem[{mem_addr[7:2], 2'd2}], mem[{mem_addr[7:2], 2'd3}]};
        end
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) overlapCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int memDiff();
        int n = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== refMem[i]) n++;
        return n;
    endfunction

    // One request end to end; junk drives a conflicting SW start during cycles 1-2.
    task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] d, input bit junk);
        int n, expLat, expReads, expWrites, expWrCyc;
        int reads = 0, writes = 0, rdCyc = 0, wrCyc = 0, doneCyc = 0;
        logic [31:0] rdAddr = 0, wrAddr = 0, wrData = 0, doneLoad = 0, waddr, expWdata;
        logic doneFault = 0, doneBusy = 0, expFault;
        longint v;

        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        expFault = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0)
                || (longint'(a) + n > MEM_BYTES);
        waddr = a & ~32'd3;
        expReads  = (!expFault && !(st && sz == 2'b10)) ? 1 : 0;
        expWrites = (!expFault && st) ? 1 : 0;
        expWrCyc  = (sz == 2'b10) ? 1 : 3;
        expLat    = expFault ? 1 : !st ? 3 : (sz == 2'b10) ? 2 : 4;

        @(negedge clk);
        checkOutput("idleBusy", busy, 0);
        checkOutput("idleDone", done, 0);
        start = 1'b1; is_store = st; size = sz; is_unsigned = uns; addr = a; store_data = d;

        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (mem_read)  begin reads++;  rdCyc = cyc; rdAddr = mem_addr; end
            if (mem_write) begin writes++; wrCyc = cyc; wrAddr = mem_addr; wrData = mem_wdata; end
            if (junk && cyc <= 2) begin
                start = 1'b1; is_store = 1'b1; size = 2'b10; addr = 32'd0; store_data = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                doneCyc = cyc; doneFault = fault; doneLoad = load_data; doneBusy = busy;
                break;
            end
        end
        start = 1'b0;

        if (!expFault) begin
            if (st) begin
                for (int i = 0; i < n; i++) refMem[a + i] = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = (v << 8) | longint'(refMem[a + i]);
                if (!uns && n < 4 && v[8 * n - 1]) v = v - (64'd1 << (8 * n));
                expLoadData = v[31:0];
            end
        end
        expWdata = {refMem[waddr[7:0]], refMem[waddr[7:0] + 8'd1],
                    refMem[waddr[7:0] + 8'd2], refMem[waddr[7:0] + 8'd3]};

        checkOutput("latency", 64'(doneCyc), 64'(expLat));
        checkOutput("fault", doneFault, expFault);
        checkOutput("loadData", doneLoad, expLoadData);
        checkOutput("busyAtDone", doneBusy, 1);
        checkOutput("readCount", 64'(reads), 64'(expReads));
        checkOutput("writeCount", 64'(writes), 64'(expWrites));
        if (expReads == 1) begin
            checkOutput("readCycle", 64'(rdCyc), 1);
            checkOutput("readAddr", rdAddr, waddr);
        end
        if (expWrites == 1) begin
            checkOutput("writeCycle", 64'(wrCyc), 64'(expWrCyc));
            checkOutput("writeAddr", wrAddr, waddr);
            checkOutput("writeData", wrData, expWdata);
        end
        checkOutput("memDiff", 64'(memDiff()), 0);
    endtask

    // SB aborted by reset sampled at the edge that ends the CAP cycle.
    task automatic resetMidStore();
        int writes = 0, dones = 0;
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; size = 2'b00; is_unsigned = 1'b0;
        addr = 32'd5; store_data = 32'h77;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_write) writes++;
            if (done) dones++;
            if (cyc == 2) rst_n = 1'b0;
            if (cyc == 3) begin
                checkOutput("rstBusy", busy, 0);
                checkOutput("rstOutputs", {done, fault, mem_read, mem_write}, 0);
                checkOutput("rstLoadData", load_data, 0);
                checkOutput("rstMemAddr", mem_addr, 0);
                checkOutput("rstMemWdata", mem_wdata, 0);
                rst_n = 1'b1;
            end
        end
        expLoadData = 32'd0;
        checkOutput("rstWrites", 64'(writes), 0);
        checkOutput("rstDones", 64'(dones), 0);
        checkOutput("rstWord", {mem[4], mem[5], mem[6], mem[7]}, 32'h1234ABCD);
        checkOutput("rstMemDiff", 64'(memDiff()), 0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;

        for (int i = 0; i < MEM_BYTES; i++) refMem[i] = 8'($urandom);
        refMem[4] = 8'h12; refMem[5] = 8'h34; refMem[6] = 8'hAB; refMem[7] = 8'hCD;
        for (int i = 0; i < MEM_BYTES; i++) begin
            @(negedge clk);
            preWe = 1'b1; preAddr = 8'(i); preData = refMem[i];
        end
        @(negedge clk);
        preWe = 1'b0;
        checkOutput("resetFlags", {busy, done, fault, mem_read, mem_write}, 0);
        checkOutput("resetLoadData", load_data, 0);
        checkOutput("resetMemAddr", mem_addr, 0);
        checkOutput("resetMemWdata", mem_wdata, 0);
        rst_n = 1'b1;

        applyStimulus(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd6, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'd6, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'd6, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'd4, 32'd0, 1'b0);
        resetMidStore();
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd5, 32'h00000077, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'd3, 32'h0000BEEF, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd6, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd256, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd12, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'd254, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd252, 32'd0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            rs = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 259));
            if ($urandom_range(0, 3) != 0) begin
                if (rs == 2'b01) ra[0] = 1'b0;
                if (rs == 2'b10) ra[1:0] = 2'b00;
            end
            applyStimulus(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom,
                          $urandom_range(0, 7) == 0);
        end

        checkOutput("strobeOverlap", 64'(overlapCount), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
